// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared state encoding and widths for the multi-cycle multiplier and divider.
package mul_div_pkg;
    localparam int HILO_W = 32;
    localparam int ITER   = 32;
    localparam int CNT_W  = $clog2(ITER);
    typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} state_e;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth recode/add step followed by the arithmetic right shift of {acc, q, q_m1}.
module booth_step
    import mul_div_pkg::*;
#(
    parameter int WIDTH = HILO_W
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q_m1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q_m1_o
);
    logic [WIDTH:0] sum;
    always_comb begin
        sum = ({q_i[0], q_m1_i} == 2'b01) ? acc_i + m_i :
              ({q_i[0], q_m1_i} == 2'b10) ? acc_i - m_i : acc_i;
        {acc_o, q_o, q_m1_o} = {sum[WIDTH], sum, q_i};
    end
endmodule

// File: rtl/booth_mult.sv
// booth_mult: multi-cycle signed WIDTHxWIDTH Booth multiplier writing the 2*WIDTH product into HI/LO.
module booth_mult
    import mul_div_pkg::*;
#(
    parameter int WIDTH = HILO_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             done,
    output logic             busy
);
    state_e             state_q;
    logic [WIDTH:0]     acc_q, acc_d, m_q;
    logic [WIDTH-1:0]   q_q, q_d, hi_q, lo_q;
    logic               qm1_q, qm1_d, done_q;
    logic [CNT_W-1:0]   cnt_q;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q_m1_i(qm1_q),
        .m_i   (m_q),
        .acc_o (acc_d),
        .q_o   (q_d),
        .q_m1_o(qm1_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) state_q <= LOAD;
                end
                LOAD: begin
                    m_q     <= {A[WIDTH-1], A};
                    acc_q   <= '0;
                    q_q     <= B;
                    qm1_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= MULT;
                end
                MULT: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) state_q <= DONE;
                end
                DONE: begin
                    // acc_q[WIDTH] is only sign extension once all steps are done
                    hi_q    <= acc_q[WIDTH-1:0];
                    lo_q    <= q_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);
endmodule

// File: doc/booth_mult.md
# booth_mult

Multi-cycle signed 32×32 multiplier producing a 64-bit product split into HI/LO registers, for the MULT instruction of the datapath. It uses radix-2 Booth recoding, one recoded bit per cycle, and pairs with the multi-cycle divider on the same HI/LO write path. The control unit pulses `start`, stalls, and samples HI/LO when `done` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset: asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  32  multiplicand, two's complement.
- `B`  in  32  multiplier, two's complement.
- `HI`  out  32  product[63:32].
- `LO`  out  32  product[31:0].
- `done`  out  1  one-cycle pulse; HI/LO hold a new result.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- Reset (async) values: state IDLE, `HI`=0, `LO`=0, `done`=0, `busy`=0, internal registers 0.
- States: IDLE, LOAD, MULT, DONE (2-bit encoding).
- IDLE
  - `start`=1 at a rising edge -> LOAD.
  - Otherwise stay in IDLE.
  - `done` is cleared here.
- LOAD
  - Capture M = sign-extended A (33 bits).
  - Set accumulator ACC (33 bits) = 0, Q = B, q₋₁ = 0, count = 0.
  - Go to MULT.
- MULT: one Booth step per cycle, selected by {Q[0], q₋₁}:
  - 01: ACC = ACC + M.
  - 10: ACC = ACC − M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {ACC, Q, q₋₁} by 1, replicating ACC[32].
  - count increments; after the 32nd step (count reaches 31) -> DONE.
- DONE
  - HI = ACC[31:0], LO = Q, `done`=1.
  - Go to IDLE.
- Width rule: the 33-bit ACC prevents overflow for M = −2^31. The product is the exact two's-complement 64-bit result for all inputs.
- A and B are sampled only in LOAD; later changes have no effect on the running operation.
- `start` outside IDLE is ignored. There is no queueing and no abort input.
- HI/LO change only in DONE. Between operations they hold the last result.

## Timing
- `start` sampled at edge N.
  - LOAD at edge N+1.
  - Booth steps at edges N+2 … N+33.
  - DONE at edge N+34: HI/LO update, `done` rises.
  - `done` falls at edge N+35.
- Latency: 35 edges from `start` sample to valid HI/LO.
- Back-to-back: `start` held high gives a new operation sampled at edge N+35. Throughput is one product per 35 cycles.
- `done` is high for exactly one cycle per completed operation.
- `busy` is high from edge N through edge N+34.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - HI/LO cleared to 0, no `done` pulse.
  - The first `start` after reset release runs a full 35-cycle operation.
- Reset and `start` together: reset wins.

## Structure
- Shared package `mul_div_pkg`:
  - State encoding constants IDLE/LOAD/MULT/DONE.
  - `ITER` = 32.
  - HI/LO width constant; the divider uses the same package.
- One combinational sub-module, `booth_step`:
  - Inputs: ACC, Q, q₋₁, M.
  - Outputs: next ACC, Q, q₋₁.
  - Verified standalone against a reference shift-add.
- The top level holds the FSM, counter, operand registers and HI/LO.

## Test plan
- A=6, B=7 -> at edge N+34: HI=0x00000000, LO=0x0000002A, `done` high for one cycle.
- A=−3 (0xFFFFFFFD), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- A=B=0x80000000 -> HI=0x40000000, LO=0x00000000. A=B=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001.
- Assert reset during the 10th Booth step -> HI=LO=0 and `done`=0 immediately. Then A=−1, B=−1 -> HI=0, LO=1 after 35 cycles.
- `start` held high with A/B changing every cycle during MULT:
  - Results match the operands present at each LOAD.
  - One `done` every 35 cycles.
  - `start` pulses while `busy`=1 have no effect.
- 10,000 random signed pairs, including 0, ±1, 0x80000000 and 0x7FFFFFFF -> {HI,LO} equals the 64-bit signed product, and latency is always 35.
